// File: rtl/dcache_mem_responder.sv
// Memory-side responder for the D-cache miss/write-through port: a word-addressed
// backing store with programmable read latency, address-change restart and counters.
`timescale 1ns/1ps
module dcache_mem_responder #(
  parameter int XLEN      = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_request,
  input  logic            mem_write,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_write_data,
  output logic            mem_ready,
  output logic [XLEN-1:0] mem_data,
  output logic            mem_busy,
  output logic            mem_err,
  output logic [31:0]     rd_count,
  output logic [31:0]     wr_count
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [31:0] CNT_LOAD = 32'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state, state_next;
  logic [31:0]     cnt, cnt_next;
  logic [XLEN-1:0] cap_addr, cap_addr_next;
  logic            ready_next;
  logic            err_next;
  logic [XLEN-1:0] data_next;
  logic [31:0]     rd_count_next;

  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic [AW-1:0]   wr_idx, rd_idx;
  logic            wr_in_range, rd_in_range, wr_commit;

  // The captured address is the full byte address so any change, even within a word, restarts.
  assign wr_idx      = mem_addr[AW+1:2];
  assign rd_idx      = cap_addr[AW+1:2];
  assign wr_in_range = (mem_addr >> (AW + 2)) == '0;
  assign rd_in_range = (cap_addr >> (AW + 2)) == '0;
  assign wr_commit   = mem_write && wr_in_range;
  assign mem_busy    = (state != IDLE);

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    cap_addr_next = cap_addr;
    ready_next    = 1'b0;
    data_next     = mem_data;
    rd_count_next = rd_count;
    err_next      = mem_write && !wr_in_range;

    case (state)
      IDLE: begin
        if (mem_request) begin
          cap_addr_next = mem_addr;
          cnt_next      = CNT_LOAD;
          state_next    = BUSY;
        end
      end
      BUSY: begin
        if (!mem_request) begin
          state_next = IDLE;
        end else if (mem_addr != cap_addr) begin
          cap_addr_next = mem_addr;
          cnt_next      = CNT_LOAD;
        end else if (cnt == '0) begin
          ready_next    = 1'b1;
          rd_count_next = rd_count + 32'd1;
          state_next    = RESP;
          // A write landing on the response edge is forwarded so the cache sees the newest word.
          if (!rd_in_range) begin
            data_next = '0;
            err_next  = 1'b1;
          end else if (wr_commit && (wr_idx == rd_idx)) begin
            data_next = mem_write_data;
          end else begin
            data_next = mem[rd_idx];
          end
        end else begin
          cnt_next = cnt - 32'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_addr  <= '0;
      mem_ready <= 1'b0;
      mem_data  <= '0;
      mem_err   <= 1'b0;
      rd_count  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cap_addr  <= cap_addr_next;
      mem_ready <= ready_next;
      mem_data  <= data_next;
      mem_err   <= err_next;
      rd_count  <= rd_count_next;
    end
  end

  // Writes are independent of the read FSM and commit on any edge with an in-range address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_count <= '0;
    end else if (wr_commit) begin
      mem[wr_idx] <= mem_write_data;
      wr_count    <= wr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: directed cases plus random traffic, scored
// against an edge-level reference model through a tagged scoreboard queue.
`timescale 1ns/1ps
module tb_dcache_mem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 1024;

  typedef struct {
    int unsigned tag;
    logic [31:0] data;
    logic [31:0] rd_cnt;
  } rd_rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_request = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic        mem_ready, mem_busy, mem_err;
  logic [31:0] mem_data, rd_count, wr_count;

  logic        req1 = 1'b0;
  logic        wr1 = 1'b0;
  logic [31:0] addr1 = '0;
  logic [31:0] wdata1 = '0;
  logic        ready1, busy1, err1;
  logic [31:0] data1, rd_count1, wr_count1;

  int unsigned edge_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  rd_rec_t     rq[$];
  int unsigned eq[$];
  rd_rec_t     mon_rec;
  logic        mon_rdy, mon_err;

  logic [31:0] ref_mem [DEPTH];
  logic        m_active, m_in_resp;
  logic [31:0] m_addr;
  int unsigned m_start;
  logic [31:0] exp_rd, exp_wr;

  dcache_mem_responder #(.XLEN(32), .MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_request(mem_request), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_ready(mem_ready),
    .mem_data(mem_data), .mem_busy(mem_busy), .mem_err(mem_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  dcache_mem_responder #(.XLEN(32), .MEM_DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_request(req1), .mem_write(wr1),
    .mem_addr(addr1), .mem_write_data(wdata1), .mem_ready(ready1),
    .mem_data(data1), .mem_busy(busy1), .mem_err(err1),
    .rd_count(rd_count1), .wr_count(wr_count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check_output(name, {31'd0, act}, {31'd0, exp});
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return (a >> ($clog2(DEPTH) + 2)) == 32'd0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % 32'(DEPTH));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    m_active  = 1'b0;
    m_in_resp = 1'b0;
    m_addr    = '0;
    m_start   = 0;
    exp_rd    = '0;
    exp_wr    = '0;
    rq.delete();
    eq.delete();
  endtask

  // A read completes LAT edges after the last edge that sampled a new address;
  // its data is the word as it stands after that edge's write.
  task automatic model_edge(input logic req, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
    int unsigned k = edge_cnt;
    logic err = 1'b0;
    rd_rec_t r;
    if (wr) begin
      if (in_range(addr)) begin
        ref_mem[widx(addr)] = wdata;
        exp_wr++;
      end else begin
        err = 1'b1;
      end
    end
    if (m_in_resp) begin
      m_in_resp = 1'b0;
    end else if (m_active) begin
      if (!req) begin
        m_active = 1'b0;
      end else if (addr != m_addr) begin
        m_addr  = addr;
        m_start = k;
      end else if (k - m_start == 32'(LAT)) begin
        r.tag    = k + 1;
        r.data   = in_range(m_addr) ? ref_mem[widx(m_addr)] : 32'd0;
        if (!in_range(m_addr)) err = 1'b1;
        exp_rd++;
        r.rd_cnt = exp_rd;
        rq.push_back(r);
        m_active  = 1'b0;
        m_in_resp = 1'b1;
      end
    end else if (req) begin
      m_active = 1'b1;
      m_addr   = addr;
      m_start  = k;
    end
    if (err) eq.push_back(k + 1);
  endtask

  task automatic apply_stimulus(input logic req, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata);
    mem_request    = req;
    mem_write      = wr;
    mem_addr       = addr;
    mem_write_data = wdata;
    @(posedge clk);
    model_edge(req, wr, addr, wdata);
    #1;
    check_bit("mem_busy", mem_busy, m_active || m_in_resp);
    check_output("wr_count", wr_count, exp_wr);
  endtask

  task automatic read_txn(input logic [31:0] addr, input int wr_pct);
    for (int c = 0; c < LAT + 2 && !m_in_resp; c++) begin
      apply_stimulus(1'b1, $urandom_range(0, 99) < wr_pct, addr, $urandom);
    end
    apply_stimulus(1'b1, 1'b0, addr, 32'd0);
  endtask

  function automatic logic [31:0] pick_addr();
    if ($urandom_range(0, 9) == 0) return 32'h0000_1000 + 32'($urandom_range(0, 3)) * 4;
    return 32'h0000_0040 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  // Monitor: every cycle the DUT's ready and err must match the scoreboard tags.
  always @(negedge clk) begin
    mon_rdy = (rq.size() > 0) && (rq[0].tag == edge_cnt);
    check_bit("mem_ready", mem_ready, mon_rdy);
    if (mon_rdy) begin
      mon_rec = rq.pop_front();
      check_output("mem_data", mem_data, mon_rec.data);
      check_output("rd_count", rd_count, mon_rec.rd_cnt);
    end
    mon_err = (eq.size() > 0) && (eq[0] == edge_cnt);
    if (mon_err) void'(eq.pop_front());
    check_bit("mem_err", mem_err, mon_err);
  end

  initial begin
    logic [31:0] a;
    int unsigned sel, h, gap;
    model_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_bit("reset_ready", mem_ready, 1'b0);
    check_output("reset_data", mem_data, 32'd0);
    check_bit("reset_busy", mem_busy, 1'b0);
    check_output("reset_rd_count", rd_count, 32'd0);
    check_output("reset_wr_count", wr_count, 32'd0);
    rst = 1'b1;

    // LATENCY=1 instance: ready in the cycle after the edge following the sampling edge
    req1  = 1'b1;
    addr1 = 32'h10;
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    check_bit("lat1_ready_t", ready1, 1'b0);
    check_bit("lat1_busy_t", busy1, 1'b1);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    check_bit("lat1_ready_t1", ready1, 1'b1);
    check_output("lat1_data", data1, 32'd0);
    check_output("lat1_rd_count", rd_count1, 32'd1);
    check_bit("lat1_err", err1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    check_bit("lat1_ready_t2", ready1, 1'b0);
    check_bit("lat1_busy_t2", busy1, 1'b0);
    req1 = 1'b0;

    read_txn(32'h40, 0);
    apply_stimulus(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    read_txn(32'h40, 0);

    // forwarding at the response edge
    apply_stimulus(1'b0, 1'b1, 32'h80, 32'h1111_1111);
    for (int c = 0; c < LAT; c++) apply_stimulus(1'b1, 1'b0, 32'h80, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h80, 32'h2222_2222);
    apply_stimulus(1'b1, 1'b0, 32'h80, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    read_txn(32'h80, 0);

    // abort, then restart on an address change
    apply_stimulus(1'b1, 1'b0, 32'h40, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h40, 32'd0);
    for (int c = 0; c < LAT + 2; c++) apply_stimulus(1'b0, 1'b0, 32'h40, 32'd0);
    check_output("abort_rd_count", rd_count, exp_rd);
    apply_stimulus(1'b0, 1'b1, 32'h44, 32'hCAFE_0044);
    apply_stimulus(1'b1, 1'b0, 32'h40, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h40, 32'd0);
    read_txn(32'h44, 0);

    // out-of-range read and write; a write alias at word 0 must not happen
    read_txn(32'h0000_1000, 0);
    apply_stimulus(1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0);
    read_txn(32'h0, 0);

    // simultaneous request and write in IDLE
    apply_stimulus(1'b1, 1'b1, 32'h48, 32'hA5A5_5A5A);
    read_txn(32'h48, 0);

    // reset in the middle of a read
    apply_stimulus(1'b1, 1'b0, 32'h40, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h40, 32'd0);
    rst = 1'b0;
    mem_request = 1'b0;
    model_reset();
    #1;
    check_bit("midreset_busy", mem_busy, 1'b0);
    check_bit("midreset_ready", mem_ready, 1'b0);
    check_output("midreset_rd_count", rd_count, 32'd0);
    check_output("midreset_wr_count", wr_count, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < LAT + 2; c++) apply_stimulus(1'b0, 1'b0, 32'h40, 32'd0);
    read_txn(32'h40, 0);

    for (int n = 0; n < 80; n++) begin
      a   = pick_addr();
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        h = $urandom_range(1, LAT);
        for (int c = 0; c < int'(h); c++) apply_stimulus(1'b1, $urandom_range(0, 2) == 0, a, $urandom);
        apply_stimulus(1'b0, 1'b0, a, 32'd0);
      end else if (sel == 1) begin
        h = $urandom_range(1, LAT);
        for (int c = 0; c < int'(h); c++) apply_stimulus(1'b1, $urandom_range(0, 2) == 0, a, $urandom);
        read_txn(pick_addr(), 30);
      end else begin
        read_txn(a, 30);
      end
      gap = $urandom_range(0, 2);
      for (int c = 0; c < int'(gap); c++) apply_stimulus(1'b0, $urandom_range(0, 2) == 0, pick_addr(), $urandom);
    end

    for (int c = 0; c < LAT + 3; c++) apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0);
    check_output("pending_reads", 32'(rq.size()), 32'd0);
    check_output("pending_errs", 32'(eq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
